// File: rtl/poly_note_ctrl.sv
// poly_note_ctrl
//   Polyphonic note allocator between uart_rx and the per-voice tone/LED
//   generators. A rising edge on UART_valid accepts UART_msg. Each non-zero
//   code goes to a voice, which plays it for C_PERIOD cycles and then clears
//   itself. Code 0 silences every voice. A message that arrives with
//   UART_err set is dropped and counted.
//
//   Ports
//     clk           master clock
//     rst           synchronous reset, active high
//     UART_err      framing/parity error flag for the current byte
//     UART_valid    data valid level; only its rising edge accepts a message
//     UART_msg      received note code
//     out           voice v code at [v*C_DATA_W +: C_DATA_W]; 0 = silent
//     voice_active  bit v high while voice v is playing
//     err_cnt       number of dropped messages, saturates at 255
//
//   Build option
//     POLY_NOTE_RELEASE_EN  When defined, a code with its MSB set is a
//                           note-off for the same code with the MSB cleared.
//
//   Per-voice states
//     state   | meaning
//     V_IDLE  | silent, code 0
//     V_PLAY  | holding code_q, timer_q counts 0 .. C_PERIOD-1
module poly_note_ctrl #(
  parameter int C_CLK_FRQ = 100_000_000,
  parameter int C_MUSIC   = 500,
  parameter int C_VOICES  = 4,
  parameter int C_DATA_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         UART_err,
  input  logic                         UART_valid,
  input  logic [C_DATA_W-1:0]          UART_msg,
  output logic [C_VOICES*C_DATA_W-1:0] out,
  output logic [C_VOICES-1:0]          voice_active,
  output logic [7:0]                   err_cnt
);

  localparam int C_PERIOD = C_CLK_FRQ / 1000 * C_MUSIC;
  localparam int TIMER_W  = $clog2(C_PERIOD);
  localparam int IDX_W    = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;

  typedef enum logic {V_IDLE, V_PLAY} voice_state_t;

  voice_state_t        state_q [C_VOICES];
  voice_state_t        state_d [C_VOICES];
  logic [C_DATA_W-1:0] code_q  [C_VOICES];
  logic [C_DATA_W-1:0] code_d  [C_VOICES];
  logic [TIMER_W-1:0]  timer_q [C_VOICES];
  logic [TIMER_W-1:0]  timer_d [C_VOICES];
  logic [IDX_W-1:0]    steal_ptr_q, steal_ptr_d;
  logic                valid_q, valid_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic             accept;
  logic             hit_found, idle_found, load;
  logic [IDX_W-1:0] hit_idx, idle_idx, load_idx;
`ifdef POLY_NOTE_RELEASE_EN
  logic [C_DATA_W-1:0] rel_code;
`endif

  always_comb begin
    valid_d     = UART_valid;
    accept      = UART_valid && !valid_q;
    err_cnt_d   = err_cnt_q;
    steal_ptr_d = steal_ptr_q;
    hit_found   = 1'b0;
    hit_idx     = '0;
    idle_found  = 1'b0;
    idle_idx    = '0;
    load        = 1'b0;
    load_idx    = '0;
`ifdef POLY_NOTE_RELEASE_EN
    rel_code    = {1'b0, UART_msg[C_DATA_W-2:0]};
`endif

    // Descending scan so the lowest matching index is the one kept.
    for (int v = C_VOICES - 1; v >= 0; v--) begin
      if (state_q[v] == V_PLAY && code_q[v] == UART_msg) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(v);
      end
      if (state_q[v] == V_IDLE) begin
        idle_found = 1'b1;
        idle_idx   = IDX_W'(v);
      end
    end

    for (int v = 0; v < C_VOICES; v++) begin
      state_d[v] = state_q[v];
      code_d[v]  = code_q[v];
      timer_d[v] = timer_q[v];
      if (state_q[v] == V_PLAY) begin
        if (timer_q[v] == TIMER_W'(C_PERIOD - 1)) begin
          state_d[v] = V_IDLE;
          code_d[v]  = '0;
          timer_d[v] = '0;
        end else begin
          timer_d[v] = timer_q[v] + TIMER_W'(1);
        end
      end
    end

    if (accept) begin
      if (UART_err) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (UART_msg == '0) begin
        for (int v = 0; v < C_VOICES; v++) begin
          state_d[v] = V_IDLE;
          code_d[v]  = '0;
          timer_d[v] = '0;
        end
`ifdef POLY_NOTE_RELEASE_EN
      end else if (UART_msg[C_DATA_W-1]) begin
        for (int v = 0; v < C_VOICES; v++) begin
          if (state_q[v] == V_PLAY && code_q[v] == rel_code) begin
            state_d[v] = V_IDLE;
            code_d[v]  = '0;
            timer_d[v] = '0;
          end
        end
`endif
      end else begin
        load = 1'b1;
        if (hit_found) begin
          load_idx = hit_idx;
        end else if (idle_found) begin
          load_idx = idle_idx;
        end else begin
          load_idx    = steal_ptr_q;
          steal_ptr_d = (steal_ptr_q == IDX_W'(C_VOICES - 1)) ? '0
                                                               : steal_ptr_q + IDX_W'(1);
        end
      end
    end

    // Applied after expiry so a load on an expiring voice keeps it playing.
    if (load) begin
      state_d[load_idx] = V_PLAY;
      code_d[load_idx]  = UART_msg;
      timer_d[load_idx] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < C_VOICES; v++) begin
        state_q[v] <= V_IDLE;
        code_q[v]  <= '0;
        timer_q[v] <= '0;
      end
      steal_ptr_q <= '0;
      valid_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      for (int v = 0; v < C_VOICES; v++) begin
        state_q[v] <= state_d[v];
        code_q[v]  <= code_d[v];
        timer_q[v] <= timer_d[v];
      end
      steal_ptr_q <= steal_ptr_d;
      valid_q     <= valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    out          = '0;
    voice_active = '0;
    for (int v = 0; v < C_VOICES; v++) begin
      out[v*C_DATA_W +: C_DATA_W] = code_q[v];
      voice_active[v]             = (state_q[v] == V_PLAY);
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_poly_note_ctrl.sv
module tb_poly_note_ctrl;

  localparam int PERIOD = 10;
`ifdef POLY_NOTE_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, err;
  logic [7:0]  msg;
  logic [31:0] out_w;
  logic [3:0]  act;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  poly_note_ctrl #(
    .C_CLK_FRQ(10_000),
    .C_MUSIC  (1),
    .C_VOICES (4),
    .C_DATA_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .UART_err    (err),
    .UART_valid  (valid),
    .UART_msg    (msg),
    .out         (out_w),
    .voice_active(act),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] o;
    logic [3:0]  a;
    logic [7:0]  e;
  } exp_t;
  exp_t sb_q[$];

  // Reference model, stepped on each rising edge.
  bit         m_play [4];
  logic [7:0] m_code [4];
  int         m_tmr  [4];
  int         m_ptr, m_err, m_tgt;
  bit         m_vprev, m_acc, m_was [4];
  exp_t       m_e;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int v = 0; v < 4; v++) begin m_play[v] = 0; m_code[v] = 0; m_tmr[v] = 0; end
      m_ptr = 0; m_err = 0; m_vprev = 0;
    end else begin
      m_acc = valid && !m_vprev;
      m_tgt = -1;
      for (int v = 0; v < 4; v++) m_was[v] = m_play[v];
      if (m_acc && !err && msg != 0 && !(REL && msg[7])) begin
        for (int v = 0; v < 4; v++) if (m_tgt < 0 && m_play[v] && m_code[v] == msg) m_tgt = v;
        for (int v = 0; v < 4; v++) if (m_tgt < 0 && !m_play[v]) m_tgt = v;
        if (m_tgt < 0) begin m_tgt = m_ptr; m_ptr = (m_ptr + 1) % 4; end
      end
      for (int v = 0; v < 4; v++) begin
        if (m_play[v]) begin
          if (m_tmr[v] == PERIOD - 1) begin m_play[v] = 0; m_code[v] = 0; m_tmr[v] = 0; end
          else m_tmr[v]++;
        end
      end
      if (m_acc && err) m_err = (m_err == 255) ? 255 : m_err + 1;
      if (m_acc && !err && msg == 0)
        for (int v = 0; v < 4; v++) begin m_play[v] = 0; m_code[v] = 0; m_tmr[v] = 0; end
      if (REL && m_acc && !err && msg[7])
        for (int v = 0; v < 4; v++)
          if (m_was[v] && m_play[v] && m_code[v] == {1'b0, msg[6:0]}) begin
            m_play[v] = 0; m_code[v] = 0; m_tmr[v] = 0;
          end
      if (m_tgt >= 0) begin m_play[m_tgt] = 1; m_code[m_tgt] = msg; m_tmr[m_tgt] = 0; end
      m_vprev = valid;
    end
    for (int v = 0; v < 4; v++) begin
      m_e.o[v*8 +: 8] = m_code[v];
      m_e.a[v]        = m_play[v];
    end
    m_e.e = 8'(m_err);
    sb_q.push_back(m_e);
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_out", out_w, e.o);
      chk("sb_active", {28'd0, act}, {28'd0, e.a});
      chk("sb_err_cnt", {24'd0, err_cnt}, {24'd0, e.e});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] m, input logic e);
    @(negedge clk);
    valid = 1'b1; msg = m; err = e;
    @(negedge clk);
    valid = 1'b0; err = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; valid = 1'b0; msg = '0; err = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    chk("rst_out", out_w, 32'h0);
    chk("rst_active", {28'd0, act}, 32'h0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'h0);

    // Single note lasts exactly one period.
    send(8'h3C, 1'b0);
    chk("t1_code", {24'd0, out_w[7:0]}, 32'h3C);
    cnt = 0;
    repeat (20) begin
      if (act == 4'b0001) cnt++;
      @(negedge clk);
    end
    chk("t1_duration", cnt, PERIOD);
    chk("t1_silent", out_w, 32'h0);

    // Five notes on four voices: fifth steals voice 0, sixth steals voice 1.
    send(8'h3C, 1'b0); send(8'h40, 1'b0); send(8'h43, 1'b0); send(8'h47, 1'b0);
    send(8'h48, 1'b0);
    chk("steal_v0", out_w, 32'h4743_4048);
    send(8'h30, 1'b0);
    chk("steal_v1", {24'd0, out_w[15:8]}, 32'h30);
    send(8'h00, 1'b0);
    chk("all_off_out", out_w, 32'h0);
    chk("all_off_active", {28'd0, act}, 32'h0);

    // Retrigger of a playing code restarts its period on the same voice.
    send(8'h3C, 1'b0);
    wait_cyc(5);
    send(8'h3C, 1'b0);
    chk("retrig_active", {28'd0, act}, 32'h1);
    cnt = 0;
    repeat (20) begin
      if (act == 4'b0001) cnt++;
      @(negedge clk);
    end
    chk("retrig_duration", cnt, PERIOD);

    // A held valid level is a single message.
    @(negedge clk);
    valid = 1'b1; msg = 8'h41;
    wait_cyc(5);
    valid = 1'b0;
    chk("hold_one_voice", $countones(act), 1);
    chk("hold_code", {24'd0, out_w[7:0]}, 32'h41);
    send(8'h55, 1'b1); send(8'h56, 1'b1); send(8'h57, 1'b1);
    chk("err_cnt3", {24'd0, err_cnt}, 32'd3);
    send(8'h00, 1'b0);
    chk("off_after_err", out_w, 32'h0);

    // Steal pointer sits at 2; make voice 2 the one expiring when the steal lands.
    send(8'h50, 1'b0); send(8'h51, 1'b0); send(8'h52, 1'b0); send(8'h53, 1'b0);
    send(8'h50, 1'b0); send(8'h51, 1'b0);
    wait_cyc(2);
    send(8'h5B, 1'b0);
    chk("expire_load_code", {24'd0, out_w[23:16]}, 32'h5B);
    chk("expire_load_active", {28'd0, act}, 32'hF);
    send(8'h5C, 1'b0);
    chk("steal_v3", {24'd0, out_w[31:24]}, 32'h5C);

    // Reset in the middle of notes.
    wait_cyc(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", out_w, 32'h0);
    chk("midrst_active", {28'd0, act}, 32'h0);
    chk("midrst_err_cnt", {24'd0, err_cnt}, 32'h0);
    rst = 1'b0;

`ifdef POLY_NOTE_RELEASE_EN
    send(8'h3C, 1'b0);
    send(8'hBC, 1'b0);
    chk("release_out", out_w, 32'h0);
    chk("release_active", {28'd0, act}, 32'h0);
    send(8'h3C, 1'b0);
    send(8'hC0, 1'b0);
    chk("release_nomatch", out_w, 32'h3C);
    chk("release_no_err", {24'd0, err_cnt}, 32'h0);
`else
    send(8'hBC, 1'b0);
    chk("msb_note_code", out_w, 32'hBC);
    chk("msb_note_active", {28'd0, act}, 32'h1);
`endif

    wait_cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
